nway_cache_control: RTL and testbench

NWAY_CACHE_CONTROL -- requirements
Module: nway_cache_control

---
 rtl/nway_cache_control.sv | 191 +++++++++++++++++++
 tb/tb_nway_cache_control.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/nway_cache_control.sv
// Control FSM and per-set tree-PLRU for an N-way set-associative cache.
// Optional hit/miss performance counters are enabled with CACHE_PERF_CNT_EN.
module nway_cache_control #(
    parameter int WAYS  = 4,
    parameter int IDX_W = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                mem_read,
    input  logic                                mem_write,
    input  logic [15:0]                         mem_address,
    output logic                                mem_resp,
    output logic                                pmem_read,
    output logic                                pmem_write,
    input  logic                                pmem_resp,
    output logic [15:0]                         pmem_address,
    input  logic [WAYS-1:0]                     way_hit,
    input  logic [WAYS-1:0]                     way_valid,
    input  logic [WAYS-1:0]                     way_dirty,
    input  logic [WAYS*(12-IDX_W)-1:0]          way_tag,
    output logic [WAYS-1:0]                     load_way,
    output logic                                write_type,
    output logic                                cache_in_mux_sel,
    output logic                                insert_mux_sel,
`ifdef CACHE_PERF_CNT_EN
    input  logic                                perf_clear,
    output logic [31:0]                         hit_count,
    output logic [31:0]                         miss_count,
`endif
    output logic [$clog2(WAYS)-1:0]             pmem_w_way_sel
);
    localparam int SETS  = 1 << IDX_W;
    localparam int TAG_W = 12 - IDX_W;
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [1:0] {ST_HIT, ST_WRITEBACK, ST_FETCH, ST_FILL} state_t;

    state_t            state_q, state_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [WAYS-2:0]   plru_q [SETS];

    logic              req, any_hit, plru_upd;
    logic [IDX_W-1:0]  idx;
    logic [WAY_W-1:0]  hit_idx, inv_idx, victim_sel, upd_way;
    logic [TAG_W-1:0]  victim_tag;
    logic              unused_offset;

    // Tree nodes are heap-ordered: node n has children 2n+1 (lower) and 2n+2 (upper).
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] t);
        logic [WAY_W-1:0] v;
        logic             b;
        int               n;
        v = '0;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b = 1'b0;
            for (int k = 0; k < WAYS - 1; k++)
                if (k == n) b = t[k];
            v = WAY_W'({v, b});
            n = 2 * n + 1 + (b ? 1 : 0);
        end
        return v;
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                   input logic [WAY_W-1:0] w);
        logic [WAYS-2:0]  r;
        logic [WAY_W-1:0] wsh;
        logic             b;
        int               n;
        r   = t;
        wsh = w;
        n   = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b   = wsh[WAY_W-1];
            wsh = wsh << 1;
            for (int k = 0; k < WAYS - 1; k++)
                if (k == n) r[k] = ~b;
            n = 2 * n + 1 + (b ? 1 : 0);
        end
        return r;
    endfunction

    assign req           = mem_read | mem_write;
    assign any_hit       = |way_hit;
    assign idx           = mem_address[4+IDX_W-1:4];
    assign unused_offset = ^mem_address[3:0];

    always_comb begin
        hit_idx    = '0;
        inv_idx    = '0;
        victim_tag = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit[w])    hit_idx = WAY_W'(w);
            if (!way_valid[w]) inv_idx = WAY_W'(w);
        end
        for (int w = 0; w < WAYS; w++)
            if (victim_q == WAY_W'(w)) victim_tag = way_tag[w*TAG_W +: TAG_W];
        victim_sel = (&way_valid) ? plru_victim(plru_q[idx]) : inv_idx;
    end

    always_comb begin
        state_d          = state_q;
        victim_d         = victim_q;
        plru_upd         = 1'b0;
        upd_way          = '0;
        mem_resp         = 1'b0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address     = {mem_address[15:4], 4'b0};
        load_way         = '0;
        write_type       = 1'b0;
        cache_in_mux_sel = 1'b0;
        insert_mux_sel   = 1'b0;
        pmem_w_way_sel   = '0;
        unique case (state_q)
            ST_HIT: begin
                if (req && any_hit) begin
                    mem_resp = 1'b1;
                    plru_upd = 1'b1;
                    upd_way  = hit_idx;
                    if (mem_write) begin
                        load_way         = way_hit;
                        write_type       = 1'b1;
                        cache_in_mux_sel = 1'b1;
                    end
                end else if (req) begin
                    victim_d = victim_sel;
                    state_d  = (way_valid[victim_sel] && way_dirty[victim_sel])
                               ? ST_WRITEBACK : ST_FETCH;
                end
            end
            ST_WRITEBACK: begin
                pmem_write     = 1'b1;
                pmem_w_way_sel = victim_q;
                pmem_address   = {victim_tag, idx, 4'b0};
                if (pmem_resp) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                pmem_read = 1'b1;
                if (pmem_resp) state_d = ST_FILL;
            end
            ST_FILL: begin
                // Fill and CPU response share this cycle; a write miss merges here.
                load_way         = WAYS'(1) << victim_q;
                insert_mux_sel   = 1'b1;
                write_type       = mem_write;
                cache_in_mux_sel = mem_write;
                plru_upd         = 1'b1;
                upd_way          = victim_q;
                mem_resp         = 1'b1;
                state_d          = ST_HIT;
            end
            default: state_d = ST_HIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HIT;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (plru_upd) plru_q[idx] <= plru_touch(plru_q[idx], upd_way);
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        hit_evt, miss_evt;

    assign hit_evt  = (state_q == ST_HIT) && req && any_hit;
    assign miss_evt = (state_q == ST_HIT) && (state_d != ST_HIT);

    always_ff @(posedge clk) begin
        if (rst || perf_clear) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_evt) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_nway_cache_control.sv
// Directed bench for nway_cache_control (WAYS=4, IDX_W=3, TAG_W=9).
module tb_nway_cache_control;
    logic        clk = 1'b0;
    logic        rst, mem_read, mem_write, pmem_resp;
    logic [15:0] mem_address, pmem_address;
    logic        mem_resp, pmem_read, pmem_write;
    logic [3:0]  way_hit, way_valid, way_dirty, load_way;
    logic [35:0] way_tag;
    logic        write_type, cache_in_mux_sel, insert_mux_sel;
    logic [1:0]  pmem_w_way_sel;
`ifdef CACHE_PERF_CNT_EN
    logic        perf_clear;
    logic [31:0] hit_count, miss_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    nway_cache_control #(.WAYS(4), .IDX_W(3)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .pmem_address(pmem_address),
        .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty),
        .way_tag(way_tag), .load_way(load_way), .write_type(write_type),
        .cache_in_mux_sel(cache_in_mux_sel), .insert_mux_sel(insert_mux_sel),
`ifdef CACHE_PERF_CNT_EN
        .perf_clear(perf_clear), .hit_count(hit_count), .miss_count(miss_count),
`endif
        .pmem_w_way_sel(pmem_w_way_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_read = 0; mem_write = 0; pmem_resp = 0; mem_address = '0;
        way_hit = '0; way_valid = '0; way_dirty = '0; way_tag = '0;
`ifdef CACHE_PERF_CNT_EN
        perf_clear = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_mem_resp",   mem_resp,     0);
        check("rst_pmem_read",  pmem_read,    0);
        check("rst_pmem_write", pmem_write,   0);
        check("rst_load_way",   load_way,     0);
        check("rst_pmem_addr",  pmem_address, 16'h0000);

        // Cold miss: all ways invalid, victim is way0.
        mem_read = 1; mem_address = 16'h0040; #1;
        check("cold_no_resp", mem_resp, 0);
        tick(); #1;
        check("cold_fetch_pread", pmem_read, 1);
        check("cold_fetch_addr",  pmem_address, 16'h0040);
        pmem_resp = 1; tick(); pmem_resp = 0; #1;
        check("cold_fill_load", load_way, 4'b0001);
        check("cold_fill_ins",  insert_mux_sel, 1);
        check("cold_fill_resp", mem_resp, 1);
        check("cold_fill_wt",   write_type, 0);
        tick(); mem_read = 0; #1;
        check("cold_back_idle", mem_resp, 0);

        // Read hit way0 with fresh PLRU, then a miss in set 4 picks way2.
        do_reset();
        way_valid = 4'hF; way_hit = 4'b0001; mem_read = 1; mem_address = 16'h0040; #1;
        check("rdhit_resp", mem_resp, 1);
        check("rdhit_load", load_way, 4'b0000);
        tick();
        way_hit = 4'b0000; mem_address = 16'h0140; #1;
        check("plru_miss_noresp", mem_resp, 0);
        tick(); #1;
        check("plru_fetch", pmem_read, 1);
        pmem_resp = 1; tick(); pmem_resp = 0; #1;
        check("plru_fill_way2", load_way, 4'b0100);
        check("plru_fill_resp", mem_resp, 1);
        tick(); mem_read = 0;

        // Touch way0 then way2 in set 5 so PLRU points at way1; way1 dirty, tag 0x1AB.
        do_reset();
        way_tag = 36'h1AB << 9; mem_address = 16'h0050; mem_read = 1;
        way_hit = 4'b0001; tick();
        way_hit = 4'b0100; tick();
        way_hit = 4'b0000; way_dirty = 4'b0010; #1;
        check("wb_miss_noresp", mem_resp, 0);
        tick(); #1;
        check("wb_pwrite", pmem_write, 1);
        check("wb_pread",  pmem_read, 0);
        check("wb_way_sel", pmem_w_way_sel, 2'd1);
        check("wb_addr", pmem_address, 16'hD5D0);
        tick(); #1;
        check("wb_hold", pmem_write, 1);
        pmem_resp = 1; tick(); pmem_resp = 0; #1;
        check("wb_fetch_pread",  pmem_read, 1);
        check("wb_fetch_pwrite", pmem_write, 0);
        check("wb_fetch_addr",   pmem_address, 16'h0050);
        pmem_resp = 1; tick(); pmem_resp = 0; #1;
        check("wb_fill_load", load_way, 4'b0010);
        check("wb_fill_resp", mem_resp, 1);
        tick(); mem_read = 0; way_dirty = 4'b0000;

        // Write hit way3, with read also asserted: treated as a write.
        mem_read = 1; mem_write = 1; way_hit = 4'b1000; #1;
        check("wrhit_load", load_way, 4'b1000);
        check("wrhit_wt",   write_type, 1);
        check("wrhit_cms",  cache_in_mux_sel, 1);
        check("wrhit_resp", mem_resp, 1);
        check("wrhit_ins",  insert_mux_sel, 0);
        tick(); mem_read = 0; mem_write = 0; way_hit = 4'b0000;

        // Write miss: way3 invalid (dirty flag ignored), fill merges the write.
        way_valid = 4'b0111; way_dirty = 4'b1000; mem_write = 1; mem_address = 16'h0070; #1;
        check("wrmiss_noresp", mem_resp, 0);
        tick(); #1;
        check("wrmiss_fetch",   pmem_read, 1);
        check("wrmiss_no_wb",   pmem_write, 0);
        pmem_resp = 1; tick(); pmem_resp = 0; #1;
        check("wrmiss_fill_load", load_way, 4'b1000);
        check("wrmiss_fill_wt",   write_type, 1);
        check("wrmiss_fill_cms",  cache_in_mux_sel, 1);
        tick(); mem_write = 0; way_dirty = 4'b0000; way_valid = 4'hF;

        // Reset mid-FETCH, then a late pmem_resp must not cause a transition.
        mem_read = 1; mem_address = 16'h0200; way_hit = 4'b0000;
        tick(); #1;
        check("midrst_fetch", pmem_read, 1);
        rst = 1; mem_read = 0; tick(); rst = 0; #1;
        check("midrst_pread", pmem_read, 0);
        check("midrst_resp",  mem_resp, 0);
        pmem_resp = 1; tick(); pmem_resp = 0; #1;
        check("late_resp_ins",  insert_mux_sel, 0);
        check("late_resp_load", load_way, 4'b0000);
        check("late_resp_pread", pmem_read, 0);
        check("late_resp_resp", mem_resp, 0);

`ifdef CACHE_PERF_CNT_EN
        perf_clear = 1; tick(); perf_clear = 0;
        mem_read = 1; way_hit = 4'b0001;
        repeat (3) tick();
        way_hit = 4'b0000;
        repeat (2) begin
            tick();
            pmem_resp = 1; tick(); pmem_resp = 0;
            tick();
        end
        mem_read = 0; #1;
        check("perf_hits",   hit_count, 32'd3);
        check("perf_misses", miss_count, 32'd2);
        perf_clear = 1; mem_read = 1; way_hit = 4'b0001; tick();
        perf_clear = 0; mem_read = 0; way_hit = 4'b0000; #1;
        check("perf_clr_hits",   hit_count, 32'd0);
        check("perf_clr_misses", miss_count, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
